// File: rtl/fpu_pkg.sv
// Shared FP constants: exception flag positions, rounding-mode encodings and
// a helper that rejects reserved frm values.
package fpu_pkg;

  localparam int FLAGS_W = 5;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  typedef enum logic [2:0] {
    FRM_RNE = 3'd0,
    FRM_RTZ = 3'd1,
    FRM_RDN = 3'd2,
    FRM_RUP = 3'd3,
    FRM_RMM = 3'd4,
    FRM_DYN = 3'd7
  } frm_t;

  // DYN is only meaningful in an instruction, so the CSR refuses it too.
  function automatic logic frm_legal(input logic [2:0] f);
    logic ok;
    case (f)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Pending-result tracker: RAW/WAW hazard detection for issue, busy flag and
// a pulse for write-backs that arrive for a register nothing was waiting on.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] rs1_sel,
  input  logic [ADDR_W-1:0] rs2_sel,
  input  logic [ADDR_W-1:0] rs3_sel,
  input  logic              issue_valid,
  input  logic [2:0]        issue_use,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic              issue_ready,
  output logic              busy,
  output logic              wb_err
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_wb_onehot;
  logic [NUM_REGS-1:0] w_issue_onehot;
  logic [NUM_REGS-1:0] w_eff_pending;
  logic                w_hazard;
  logic                w_accept;
  logic                r_wb_err;

  always_comb begin
    w_wb_onehot    = '0;
    w_issue_onehot = '0;
    if (wb_valid) begin
      w_wb_onehot[wb_rd] = 1'b1;
    end else begin
      w_wb_onehot = '0;
    end
    w_issue_onehot[issue_rd] = 1'b1;
  end

  // A write-back landing this cycle already resolves its register's hazard.
  assign w_eff_pending = r_pending & ~w_wb_onehot;
  assign w_hazard = (issue_use[0] & w_eff_pending[rs1_sel]) |
                    (issue_use[1] & w_eff_pending[rs2_sel]) |
                    (issue_use[2] & w_eff_pending[rs3_sel]) |
                    w_eff_pending[issue_rd];
  assign issue_ready = ~w_hazard;
  assign w_accept    = issue_valid & ~w_hazard;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pending <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      r_pending <= w_eff_pending | (w_accept ? w_issue_onehot : '0);
      r_wb_err  <= wb_valid & ~r_pending[wb_rd];
    end
  end

  assign busy   = |r_pending;
  assign wb_err = r_wb_err;

endmodule

// File: rtl/fpu_regfile_sb.sv
// FP register file with three bypassed read ports, an issue scoreboard and
// the frm/fflags CSR state.
module fpu_regfile_sb
  import fpu_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REGS   = 32,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [ADDR_W-1:0]     rs1_sel,
  input  logic [ADDR_W-1:0]     rs2_sel,
  input  logic [ADDR_W-1:0]     rs3_sel,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] rs3_data,
  input  logic                  issue_valid,
  input  logic [2:0]            issue_use,
  input  logic [ADDR_W-1:0]     issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [FLAGS_W-1:0]    wb_flags,
  input  logic                  csr_frm_we,
  input  logic [2:0]            csr_frm_wdata,
  input  logic                  csr_fflags_we,
  input  logic [FLAGS_W-1:0]    csr_fflags_wdata,
  output logic [2:0]            frm_out,
  output logic [FLAGS_W-1:0]    fflags_out,
  output logic                  busy,
  output logic                  wb_err
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [2:0]            r_frm;
  logic [FLAGS_W-1:0]    r_fflags;
  logic [FLAGS_W-1:0]    w_fflags_base;
  logic [FLAGS_W-1:0]    w_fflags_next;

  fpu_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clk         (clk),
    .n_rst       (n_rst),
    .rs1_sel     (rs1_sel),
    .rs2_sel     (rs2_sel),
    .rs3_sel     (rs3_sel),
    .issue_valid (issue_valid),
    .issue_use   (issue_use),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .issue_ready (issue_ready),
    .busy        (busy),
    .wb_err      (wb_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_valid) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = r_regs[rs1_sel];
    rs2_data = r_regs[rs2_sel];
    rs3_data = r_regs[rs3_sel];
    if (wb_valid && (wb_rd == rs1_sel)) rs1_data = wb_data;
    else                                rs1_data = r_regs[rs1_sel];
    if (wb_valid && (wb_rd == rs2_sel)) rs2_data = wb_data;
    else                                rs2_data = r_regs[rs2_sel];
    if (wb_valid && (wb_rd == rs3_sel)) rs3_data = wb_data;
    else                                rs3_data = r_regs[rs3_sel];
  end

  // OR-ing the write-back flags after the CSR mux keeps a same-cycle result's flags.
  assign w_fflags_base = csr_fflags_we ? csr_fflags_wdata : r_fflags;
  assign w_fflags_next = w_fflags_base | (wb_valid ? wb_flags : {FLAGS_W{1'b0}});

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_frm    <= FRM_RNE;
      r_fflags <= '0;
    end else begin
      r_fflags <= w_fflags_next;
      if (csr_frm_we && frm_legal(csr_frm_wdata)) r_frm <= csr_frm_wdata;
      else                                         r_frm <= r_frm;
    end
  end

  assign frm_out    = r_frm;
  assign fflags_out = r_fflags;

endmodule
